pb_window_reader: RTL and testbench

- Read-side engine for the 4-bit pixel buffer; runs on the VGA clock domain via a second read port.
- Software supplies a centre coordinate and raises a request; the block fetches either a single pixel or the full 3x3 neighbourhood.
- It returns the centre pixel and the 8-bit neighbourhood sum, which software forwards to the divide-by-9 PIO path.
- Handshake is four-phase req/ack across the 50 MHz PIO to VGA clock boundary.

---
 rtl/pb_window_pkg.sv | 32 +++
 rtl/pb_window_reader_sync_2ff.sv | 24 ++
 rtl/pb_window_reader.sv | 185 ++++++++++++++++++
 tb/tb_pb_window_reader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pb_window_pkg.sv
// Shared constants, state type and 3x3 offset table for the pixel-buffer
// window reader.
package pb_window_pkg;

    localparam int IMG_W_DEF = 160;
    localparam int IMG_H_DEF = 120;
    localparam int NUM_TAPS  = 9;

    localparam logic [3:0] CENTRE_IDX = 4'd4;
    localparam logic [3:0] LAST_IDX   = 4'd8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    // Raster order: top row, middle row, bottom row.
    localparam logic signed [1:0] DX_TAB [NUM_TAPS] = '{
        -2'sd1, 2'sd0, 2'sd1,
        -2'sd1, 2'sd0, 2'sd1,
        -2'sd1, 2'sd0, 2'sd1
    };

    localparam logic signed [1:0] DY_TAB [NUM_TAPS] = '{
        -2'sd1, -2'sd1, -2'sd1,
        2'sd0,  2'sd0,  2'sd0,
        2'sd1,  2'sd1,  2'sd1
    };

endpackage

// File: rtl/pb_window_reader_sync_2ff.sv
// Single-bit two-flop synchroniser with asynchronous active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/pb_window_reader.sv
// Pixel-buffer 3x3 / single-pixel read engine with four-phase req/ack.
// Build option: WINDOW_ZERO_PAD_EN makes out-of-frame neighbours read as 0.
module pb_window_reader
    import pb_window_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int RD_LAT = 2,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              mode,
    input  logic [7:0]        x_in,
    input  logic [6:0]        y_in,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [3:0]        rd_data,
    output logic              busy,
    output logic              ack,
    output logic [3:0]        centre_px,
    output logic [7:0]        win_sum,
    output logic              coord_err
);

    state_t            r_state;
    logic [7:0]        r_x;
    logic [6:0]        r_y;
    logic              r_mode;
    logic [3:0]        r_cnt;
    logic [RD_LAT-1:0] r_slot;
    logic [RD_LAT-1:0] r_vld;
    logic [RD_LAT-1:0] r_ctr;
    logic [8:0]        r_acc;
    logic [3:0]        r_ctr_px;
    logic              r_busy;
    logic              r_ack;
    logic [3:0]        r_centre;
    logic [7:0]        r_sum;
    logic              r_err;

    logic              w_req_s;
    logic              w_issue;
    logic              w_last;
    logic signed [1:0] w_dx;
    logic signed [1:0] w_dy;
    logic [9:0]        w_nx;
    logic [9:0]        w_ny;
    logic              w_x_lo;
    logic              w_x_hi;
    logic              w_y_lo;
    logic              w_y_hi;
    logic [7:0]        w_cx;
    logic [6:0]        w_cy;
    logic [ADDR_W-1:0] w_addr;
    logic              w_slot_in;
    logic              w_vld_in;
    logic              w_ctr_in;
    logic [RD_LAT-1:0] w_slot_nxt;
    logic [RD_LAT-1:0] w_vld_nxt;
    logic [RD_LAT-1:0] w_ctr_nxt_sr;
    logic [3:0]        w_add;
    logic [8:0]        w_acc_nxt;
    logic [3:0]        w_ctr_px_nxt;
    logic              w_drained;

    sync_2ff u_req_sync (
        .clk   (clk),
        .reset (reset),
        .d     (req),
        .q     (w_req_s)
    );

    assign w_issue = (r_state == ISSUE);
    assign w_last  = !r_mode || (r_cnt == LAST_IDX);

    assign w_dx = DX_TAB[r_cnt];
    assign w_dy = DY_TAB[r_cnt];
    assign w_nx = {2'b00, r_x} + {{8{w_dx[1]}}, w_dx};
    assign w_ny = {3'b000, r_y} + {{8{w_dy[1]}}, w_dy};

    assign w_x_lo = w_nx[9];
    assign w_x_hi = !w_nx[9] && (w_nx[8:0] > 9'(IMG_W - 1));
    assign w_y_lo = w_ny[9];
    assign w_y_hi = !w_ny[9] && (w_ny[8:0] > 9'(IMG_H - 1));

    // Edge replicate: clamp each axis to the nearest in-frame coordinate.
    assign w_cx = w_x_lo ? 8'd0 : (w_x_hi ? 8'(IMG_W - 1) : w_nx[7:0]);
    assign w_cy = w_y_lo ? 7'd0 : (w_y_hi ? 7'(IMG_H - 1) : w_ny[6:0]);

    assign w_addr  = ADDR_W'(int'(w_cy) * IMG_W + int'(w_cx));
    assign rd_addr = w_issue ? w_addr : '0;

    assign w_slot_in = w_issue;
`ifdef WINDOW_ZERO_PAD_EN
    assign w_vld_in = w_issue && !(w_x_lo || w_x_hi || w_y_lo || w_y_hi);
`else
    assign w_vld_in = w_issue;
`endif
    assign w_ctr_in = w_issue && (r_cnt == CENTRE_IDX);

    assign w_slot_nxt   = (r_slot << 1) | RD_LAT'(w_slot_in);
    assign w_vld_nxt    = (r_vld << 1) | RD_LAT'(w_vld_in);
    assign w_ctr_nxt_sr = (r_ctr << 1) | RD_LAT'(w_ctr_in);

    assign w_add        = r_vld[RD_LAT-1] ? rd_data : 4'd0;
    assign w_acc_nxt    = r_acc + {5'd0, w_add};
    assign w_ctr_px_nxt = r_ctr[RD_LAT-1] ? rd_data : r_ctr_px;
    assign w_drained    = (w_slot_nxt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_x      <= '0;
            r_y      <= '0;
            r_mode   <= 1'b0;
            r_cnt    <= '0;
            r_slot   <= '0;
            r_vld    <= '0;
            r_ctr    <= '0;
            r_acc    <= '0;
            r_ctr_px <= '0;
            r_busy   <= 1'b0;
            r_ack    <= 1'b0;
            r_centre <= '0;
            r_sum    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_slot   <= w_slot_nxt;
            r_vld    <= w_vld_nxt;
            r_ctr    <= w_ctr_nxt_sr;
            r_acc    <= w_acc_nxt;
            r_ctr_px <= w_ctr_px_nxt;
            unique case (r_state)
                IDLE: begin
                    if (w_req_s && !r_ack) begin
                        r_x    <= (int'(x_in) >= IMG_W) ? 8'(IMG_W - 1) : x_in;
                        r_y    <= (int'(y_in) >= IMG_H) ? 7'(IMG_H - 1) : y_in;
                        r_err  <= (int'(x_in) >= IMG_W) ||
                                  (int'(y_in) >= IMG_H);
                        r_mode <= mode;
                        r_cnt  <= mode ? 4'd0 : CENTRE_IDX;
                        r_acc  <= '0;
                        r_busy <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_last) begin
                        r_state <= DRAIN;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                DRAIN: begin
                    if (w_drained) begin
                        r_sum    <= w_acc_nxt[7:0];
                        r_centre <= w_ctr_px_nxt;
                        r_busy   <= 1'b0;
                        if (w_req_s) begin
                            r_ack   <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                DONE: begin
                    if (!w_req_s) begin
                        r_ack   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign ack       = r_ack;
    assign centre_px = r_centre;
    assign win_sum   = r_sum;
    assign coord_err = r_err;

endmodule

// File: tb/tb_pb_window_reader.sv
// Scoreboard bench for pb_window_reader against a behavioural pixel model.
module tb_pb_window_reader;

    localparam int W      = 160;
    localparam int H      = 120;
    localparam int RD_LAT = 2;
    localparam int ADDR_W = 15;

    typedef struct {
        int c;
        int s;
        int e;
        int lat;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req = 1'b0;
    logic              mode = 1'b0;
    logic [7:0]        x_in = '0;
    logic [6:0]        y_in = '0;
    logic [ADDR_W-1:0] rd_addr;
    logic [3:0]        rd_data = '0;
    logic              busy;
    logic              ack;
    logic [3:0]        centre_px;
    logic [7:0]        win_sum;
    logic              coord_err;

    logic [3:0] mem [W*H];
    logic [3:0] pipe = '0;
    int         cyc = 0;
    int         t_req = 0;
    int         checks = 0;
    int         errors = 0;
    logic       ack_q = 1'b0;
    exp_t       exp_q [$];
    exp_t       mon_e;

    pb_window_reader #(
        .IMG_W  (W),
        .IMG_H  (H),
        .RD_LAT (RD_LAT),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .mode      (mode),
        .x_in      (x_in),
        .y_in      (y_in),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy),
        .ack       (ack),
        .centre_px (centre_px),
        .win_sum   (win_sum),
        .coord_err (coord_err)
    );

    always #5 clk = ~clk;

    // Pixel buffer: two-cycle read latency.
    always @(posedge clk) begin
        pipe    <= mem[rd_addr];
        rd_data <= pipe;
        cyc     <= cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model(input int x, input int y, input bit m,
                         output exp_t e);
        int cx, cy, s, nx, ny;
        e.e = ((x >= W) || (y >= H)) ? 1 : 0;
        cx = (x >= W) ? W - 1 : x;
        cy = (y >= H) ? H - 1 : y;
        e.c = int'(mem[cy*W + cx]);
        s = 0;
        if (!m) begin
            s = e.c;
        end else begin
            for (int dy = -1; dy <= 1; dy++) begin
                for (int dx = -1; dx <= 1; dx++) begin
                    nx = cx + dx;
                    ny = cy + dy;
`ifdef WINDOW_ZERO_PAD_EN
                    if (nx < 0 || nx >= W || ny < 0 || ny >= H) continue;
`endif
                    if (nx < 0) nx = 0;
                    if (nx >= W) nx = W - 1;
                    if (ny < 0) ny = 0;
                    if (ny >= H) ny = H - 1;
                    s += int'(mem[ny*W + nx]);
                end
            end
        end
        e.s = s;
        e.lat = (m ? 9 : 1) + RD_LAT + 3;
    endtask

    task automatic wait_ack(input logic lvl, input string name);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ack === lvl) return;
        end
        chk({name, "_timeout"}, int'(ack), int'(lvl));
    endtask

    task automatic wait_busy(input logic lvl, input string name);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy === lvl) return;
        end
        chk({name, "_timeout"}, int'(busy), int'(lvl));
    endtask

    task automatic do_req(input int x, input int y, input bit m);
        exp_t e;
        model(x, y, m, e);
        @(negedge clk);
        x_in = 8'(x);
        y_in = 7'(y);
        mode = m;
        req = 1'b1;
        t_req = cyc;
        exp_q.push_back(e);
        wait_ack(1'b1, "ack_rise");
        @(negedge clk);
        req = 1'b0;
        wait_ack(1'b0, "ack_fall");
        repeat (2) @(negedge clk);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < W*H; i++) mem[i] = 4'($urandom_range(0, 15));
    endtask

    // Monitor: every rising ack must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && ack && !ack_q) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("centre_px", int'(centre_px), mon_e.c);
                chk("win_sum", int'(win_sum), mon_e.s);
                chk("coord_err", int'(coord_err), mon_e.e);
                chk("latency", cyc - t_req, mon_e.lat);
                chk("busy_at_ack", int'(busy), 0);
            end
        end
        ack_q <= ack;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int x, y;
        fill_rand();
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ack", int'(ack), 0);
        chk("rst_centre", int'(centre_px), 0);
        chk("rst_sum", int'(win_sum), 0);
        chk("rst_err", int'(coord_err), 0);
        chk("rst_addr", int'(rd_addr), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                mem[(10+dy)*W + 10 + dx] = 4'd15;
        do_req(10, 10, 1'b1);

        mem[0] = 4'd5;
        mem[1] = 4'd1;
        mem[W] = 4'd1;
        mem[W+1] = 4'd1;
        do_req(0, 0, 1'b1);

        mem[119*W + 159] = 4'd7;
        do_req(159, 119, 1'b0);

        do_req(200, 50, 1'b1);
        do_req(200, 50, 1'b0);
        do_req(159, 0, 1'b1);

        // Abandon during ISSUE: no ack, results still refreshed.
        model(70, 30, 1'b1, e);
        @(negedge clk);
        x_in = 8'd70;
        y_in = 7'd30;
        mode = 1'b1;
        req = 1'b1;
        wait_busy(1'b1, "abandon_busy_rise");
        req = 1'b0;
        wait_busy(1'b0, "abandon_busy_fall");
        chk("abandon_ack", int'(ack), 0);
        chk("abandon_sum", int'(win_sum), e.s);
        chk("abandon_centre", int'(centre_px), e.c);
        repeat (4) @(negedge clk);
        chk("abandon_ack_late", int'(ack), 0);
        do_req(71, 31, 1'b1);

        // Reset in the middle of ISSUE.
        @(negedge clk);
        x_in = 8'd40;
        y_in = 7'd40;
        mode = 1'b1;
        req = 1'b1;
        wait_busy(1'b1, "rst_mid_busy");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        req = 1'b0;
        #1;
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_ack", int'(ack), 0);
        chk("rstmid_centre", int'(centre_px), 0);
        chk("rstmid_sum", int'(win_sum), 0);
        chk("rstmid_err", int'(coord_err), 0);
        chk("rstmid_addr", int'(rd_addr), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        do_req(40, 40, 1'b1);

        for (int n = 0; n < 30; n++) begin
            if (n % 6 == 0) fill_rand();
            case ($urandom_range(0, 3))
                0: x = 0;
                1: x = 159;
                default: x = $urandom_range(0, 255);
            endcase
            y = (($urandom_range(0, 3)) == 0) ? 119 : $urandom_range(0, 127);
            do_req(x, y, 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
